// File: rtl/rt_pkg.sv
// rtl/rt_pkg.sv - shared types and defaults for the RT frame dispatcher
package rt_pkg;

    localparam int H_RES_DEF = 640;
    localparam int V_RES_DEF = 480;

    typedef logic [3:0] pixel_t;
    typedef logic [9:0] xcoord_t;
    typedef logic [8:0] ycoord_t;

    typedef enum logic [2:0] {
        IDLE,
        WAIT_IDLE,
        ISSUE,
        WAIT_ACK,
        WAIT_DONE,
        WRITE,
        FRAME_END
    } dispatch_state_t;

endpackage

// File: rtl/rt_raster_counter.sv
// rtl/rt_raster_counter.sv - raster X/Y scan and linear framebuffer address
module rt_raster_counter
    import rt_pkg::*;
#(
    parameter int H_RES  = H_RES_DEF,
    parameter int V_RES  = V_RES_DEF,
    parameter int ADDR_W = 19
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clear,
    input  logic              advance,
    output logic [9:0]        x,
    output logic [8:0]        y,
    output logic [ADDR_W-1:0] addr,
    output logic              last
);

    localparam logic [9:0] X_MAX = 10'(H_RES - 1);
    localparam logic [8:0] Y_MAX = 9'(V_RES - 1);

    logic x_last;
    logic y_last;

    assign x_last = (x == X_MAX);
    assign y_last = (y == Y_MAX);
    assign last   = x_last && y_last;

    // addr tracks Y*H_RES+X incrementally, so no multiplier is needed
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            x    <= '0;
            y    <= '0;
            addr <= '0;
        end else if (advance) begin
            if (x_last) begin
                x <= '0;
                y <= y_last ? '0 : y + 1'b1;
            end else begin
                x <= x + 1'b1;
            end
            addr <= last ? '0 : addr + 1'b1;
        end
    end

endmodule

// File: rtl/rt_frame_dispatcher.sv
// rtl/rt_frame_dispatcher.sv - per-pixel request sequencer between RT core and framebuffer
module rt_frame_dispatcher
    import rt_pkg::*;
#(
    parameter int H_RES       = H_RES_DEF,
    parameter int V_RES       = V_RES_DEF,
    parameter int ADDR_W      = 19,
    parameter int ACK_TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              run,
    output logic              core_enable,
    output logic [9:0]        core_x,
    output logic [8:0]        core_y,
    input  logic              core_ready,
    input  logic [3:0]        core_pixel,
    output logic              fb_we,
    output logic [ADDR_W-1:0] fb_addr,
    output logic [3:0]        fb_data,
    input  logic              fb_wait,
    output logic              busy,
    output logic              frame_done,
    output logic [15:0]       frame_count,
    output logic              err
);

    localparam int              TMO_W    = $clog2(ACK_TIMEOUT + 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(ACK_TIMEOUT - 1);

    dispatch_state_t   state;
    logic [TMO_W-1:0]  tmo;
    logic [ADDR_W-1:0] addr;
    logic              last;
    logic              clear;
    logic              advance;

    assign clear   = (state == IDLE) && run;
    assign advance = (state == WRITE) && !fb_wait;

    rt_raster_counter #(
        .H_RES  (H_RES),
        .V_RES  (V_RES),
        .ADDR_W (ADDR_W)
    ) u_raster (
        .clk     (clk),
        .reset   (reset),
        .clear   (clear),
        .advance (advance),
        .x       (core_x),
        .y       (core_y),
        .addr    (addr),
        .last    (last)
    );

    // Strobes are pure state decodes so no input reaches an output combinationally
    assign core_enable = (state == ISSUE);
    assign fb_we       = (state == WRITE);
    assign busy        = (state != IDLE);
    assign frame_done  = (state == FRAME_END);

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            tmo         <= '0;
            fb_addr     <= '0;
            fb_data     <= '0;
            frame_count <= '0;
            err         <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (run) begin
                        state <= WAIT_IDLE;
                    end
                end
                WAIT_IDLE: begin
                    if (core_ready) begin
                        state <= ISSUE;
                    end
                end
                ISSUE: begin
                    tmo   <= '0;
                    state <= WAIT_ACK;
                end
                WAIT_ACK: begin
                    // A core that never drops READY missed the pulse; retry the same pixel
                    if (!core_ready) begin
                        state <= WAIT_DONE;
                    end else if (tmo == TMO_LAST) begin
                        err   <= 1'b1;
                        state <= WAIT_IDLE;
                    end else begin
                        tmo <= tmo + 1'b1;
                    end
                end
                WAIT_DONE: begin
                    if (core_ready) begin
                        fb_data <= core_pixel;
                        fb_addr <= addr;
                        state   <= WRITE;
                    end
                end
                WRITE: begin
                    if (!fb_wait) begin
                        state <= last ? FRAME_END : WAIT_IDLE;
                    end
                end
                FRAME_END: begin
                    frame_count <= frame_count + 1'b1;
                    state       <= run ? WAIT_IDLE : IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rt_frame_dispatcher.sv
// tb/tb_rt_frame_dispatcher.sv - self-checking bench with core/framebuffer models
module tb_rt_frame_dispatcher;

    localparam int H   = 4;
    localparam int V   = 3;
    localparam int NPX = H * V;
    localparam int AW  = 19;
    localparam int TMO = 8;
    localparam int LAT = 5;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          run = 1'b0;
    logic          core_enable;
    logic [9:0]    core_x;
    logic [8:0]    core_y;
    logic          core_ready = 1'b1;
    logic [3:0]    core_pixel = 4'd0;
    logic          fb_we;
    logic [AW-1:0] fb_addr;
    logic [3:0]    fb_data;
    logic          fb_wait = 1'b0;
    logic          busy;
    logic          frame_done;
    logic [15:0]   frame_count;
    logic          err;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    rt_frame_dispatcher #(
        .H_RES       (H),
        .V_RES       (V),
        .ADDR_W      (AW),
        .ACK_TIMEOUT (TMO)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .run         (run),
        .core_enable (core_enable),
        .core_x      (core_x),
        .core_y      (core_y),
        .core_ready  (core_ready),
        .core_pixel  (core_pixel),
        .fb_we       (fb_we),
        .fb_addr     (fb_addr),
        .fb_data     (fb_data),
        .fb_wait     (fb_wait),
        .busy        (busy),
        .frame_done  (frame_done),
        .frame_count (frame_count),
        .err         (err)
    );

    // bench-side state of the core and framebuffer models
    bit       stuck_core = 0;
    bit       rand_wait = 0;
    int       stall_addr = -1;
    int       stall_left = 0;
    int       core_left = 0;
    logic [3:0] core_res = 4'd0;
    int       cyc = 0;
    int       err_cyc = -1;
    int       pending = 0;
    int       overlap_err = 0;
    int       en_busy = 0;
    int       hold_bad = 0;
    int       we_at_stall = 0;
    bit       prev_stalled = 0;
    int       prev_addr = 0;
    int       prev_data = 0;
    int       frame_done_cnt = 0;
    int       wr_addr[$];
    int       wr_data[$];
    int       req_x[$];
    int       req_y[$];
    int       en_cyc[$];
    int       done_pos[$];

    function automatic int exp_data(input int a);
        int px = a % H;
        int py = (a / H) % V;
        return (px ^ py) & 15;
    endfunction

    // Samples DUT outputs first, then drives the inputs that the next rising edge will see
    always @(negedge clk) begin
        cyc++;
        if (err && err_cyc < 0) err_cyc = cyc;
        if (frame_done) begin
            frame_done_cnt++;
            done_pos.push_back(wr_addr.size());
        end
        if (core_enable) begin
            en_cyc.push_back(cyc);
            req_x.push_back(int'(core_x));
            req_y.push_back(int'(core_y));
            if (!core_ready) en_busy++;
            if (pending != 0 && !stuck_core) overlap_err++;
            pending = 1;
            if (!stuck_core) begin
                core_ready = 1'b0;
                core_res   = core_x[3:0] ^ core_y[3:0];
                core_pixel = 4'($urandom);
                core_left  = LAT;
            end
        end else if (core_left > 0) begin
            core_left--;
            if (core_left == 0) begin
                core_ready = 1'b1;
                core_pixel = core_res;
            end
        end
        if (fb_we) begin
            if (prev_stalled && (int'(fb_addr) != prev_addr || int'(fb_data) != prev_data)) hold_bad++;
            if (int'(fb_addr) == stall_addr) we_at_stall++;
            if (stall_left > 0 && int'(fb_addr) == stall_addr) begin
                fb_wait = 1'b1;
                stall_left--;
            end else begin
                fb_wait = rand_wait && ($urandom_range(0, 3) == 0);
            end
            prev_stalled = fb_wait;
            prev_addr    = int'(fb_addr);
            prev_data    = int'(fb_data);
            if (!fb_wait) begin
                wr_addr.push_back(int'(fb_addr));
                wr_data.push_back(int'(fb_data));
                pending = 0;
            end
        end else begin
            prev_stalled = 0;
            fb_wait = rand_wait && ($urandom_range(0, 1) == 1);
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic clear_log();
        wr_addr.delete();
        wr_data.delete();
        req_x.delete();
        req_y.delete();
        en_cyc.delete();
        done_pos.delete();
        pending = 0;
        overlap_err = 0;
        en_busy = 0;
        hold_bad = 0;
        we_at_stall = 0;
        frame_done_cnt = 0;
        err_cyc = -1;
        stall_addr = -1;
        stall_left = 0;
    endtask

    task automatic reset_dut();
        run = 1'b0;
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        clear_log();
    endtask

    task automatic wait_frames(input int target, input int budget, output bit ok);
        int n = 0;
        while (frame_done_cnt < target && n < budget) begin
            tick();
            n++;
        end
        ok = (frame_done_cnt >= target);
    endtask

    task automatic test_reset();
        reset_dut();
        n_cmp++;
        if ({core_enable, core_x, core_y, fb_we, fb_addr, fb_data, busy, frame_done, frame_count, err} !== '0) begin
            n_bad++;
            $display("FAIL reset_outputs: got en=%0b x=%0d y=%0d we=%0b addr=%0d data=%0d busy=%0b done=%0b cnt=%0d err=%0b, want all 0",
                     core_enable, core_x, core_y, fb_we, fb_addr, fb_data, busy, frame_done, frame_count, err);
        end
        tick();
        n_cmp++;
        if (busy !== 1'b0 || core_enable !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_idle_no_run: busy=%0b en=%0b, want 0 0", busy, core_enable);
        end
    endtask

    task automatic test_single_frame();
        bit ok;
        reset_dut();
        run = 1'b1;
        wait_frames(1, 1000, ok);
        run = 1'b0;
        n_cmp++;
        if (!ok) begin
            n_bad++;
            $display("FAIL frame1_timeout: frames=%0d want 1", frame_done_cnt);
        end
        tick();
        n_cmp++;
        if (frame_count !== 16'd1) begin
            n_bad++;
            $display("FAIL frame1_count: got %0d want 1", frame_count);
        end
        n_cmp++;
        if (wr_addr.size() != NPX || done_pos.size() != 1 || (done_pos.size() > 0 && done_pos[0] != NPX)) begin
            n_bad++;
            $display("FAIL frame1_writes: writes=%0d dones=%0d want %0d writes and one done after the last", wr_addr.size(), done_pos.size(), NPX);
        end
        for (int i = 0; i < wr_addr.size() && i < NPX; i++) begin
            n_cmp++;
            if (wr_addr[i] != i || wr_data[i] != exp_data(i) || req_x[i] != i % H || req_y[i] != i / H) begin
                n_bad++;
                $display("FAIL frame1_px%0d: addr=%0d data=%0d req=(%0d,%0d) want addr=%0d data=%0d req=(%0d,%0d)",
                         i, wr_addr[i], wr_data[i], req_x[i], req_y[i], i, exp_data(i), i % H, i / H);
            end
        end
    endtask

    task automatic test_fb_wait();
        bit ok;
        int n5 = 0;
        reset_dut();
        stall_addr = 5;
        stall_left = 3;
        run = 1'b1;
        wait_frames(1, 1000, ok);
        run = 1'b0;
        tick();
        foreach (wr_addr[i]) if (wr_addr[i] == 5) n5++;
        n_cmp++;
        if (!ok || we_at_stall != 4 || n5 != 1) begin
            n_bad++;
            $display("FAIL fbwait_hold: done=%0b we_cycles=%0d writes_at_5=%0d want 1 4 1", ok, we_at_stall, n5);
        end
        n_cmp++;
        if (hold_bad != 0 || overlap_err != 0) begin
            n_bad++;
            $display("FAIL fbwait_stable: changes=%0d extra_enables=%0d want 0 0", hold_bad, overlap_err);
        end
        n_cmp++;
        if (wr_addr.size() != NPX || (wr_addr.size() > 6 && (wr_addr[5] != 5 || wr_data[5] != exp_data(5) || wr_addr[6] != 6))) begin
            n_bad++;
            $display("FAIL fbwait_sequence: writes=%0d want %0d in order", wr_addr.size(), NPX);
        end
    endtask

    task automatic test_run_drop();
        bit ok;
        int n = 0;
        int en_before;
        reset_dut();
        run = 1'b1;
        while (wr_addr.size() < 6 && n < 500) begin
            tick();
            n++;
        end
        tick();
        tick();
        run = 1'b0;
        wait_frames(1, 1000, ok);
        tick();
        en_before = en_cyc.size();
        n_cmp++;
        if (!ok || busy !== 1'b0) begin
            n_bad++;
            $display("FAIL rundrop_idle: done=%0b busy=%0b want 1 0", ok, busy);
        end
        repeat (40) tick();
        n_cmp++;
        if (en_cyc.size() != en_before || busy !== 1'b0 || frame_done_cnt != 1) begin
            n_bad++;
            $display("FAIL rundrop_quiet: enables %0d->%0d busy=%0b frames=%0d want no new enables, busy 0, 1 frame",
                     en_before, en_cyc.size(), busy, frame_done_cnt);
        end
        for (int i = 0; i < wr_addr.size(); i++) begin
            n_cmp++;
            if (i >= NPX || wr_addr[i] != i || wr_data[i] != exp_data(i)) begin
                n_bad++;
                $display("FAIL rundrop_px%0d: addr=%0d data=%0d want addr=%0d data=%0d", i, wr_addr[i], wr_data[i], i, exp_data(i));
            end
        end
        n_cmp++;
        if (wr_addr.size() != NPX) begin
            n_bad++;
            $display("FAIL rundrop_count: got %0d writes want %0d", wr_addr.size(), NPX);
        end
    endtask

    task automatic test_ack_timeout();
        int n = 0;
        bit err_before = 1'b1;
        reset_dut();
        run = 1'b1;
        while (wr_addr.size() < 5 && n < 500) begin
            tick();
            n++;
        end
        err_before = err;
        stuck_core = 1;
        n = 0;
        while (en_cyc.size() < 7 && n < 200) begin
            tick();
            n++;
        end
        n_cmp++;
        if (en_cyc.size() < 7 || err_before !== 1'b0) begin
            n_bad++;
            $display("FAIL timeout_retry_seen: enables=%0d err_before=%0b want >=7 and 0", en_cyc.size(), err_before);
        end else begin
            n_cmp++;
            if (err_cyc - en_cyc[5] != TMO + 1 || en_cyc[6] - en_cyc[5] != TMO + 2) begin
                n_bad++;
                $display("FAIL timeout_timing: err after %0d reissue after %0d cycles want %0d %0d",
                         err_cyc - en_cyc[5], en_cyc[6] - en_cyc[5], TMO + 1, TMO + 2);
            end
            n_cmp++;
            if (req_x[5] != 1 || req_y[5] != 1 || req_x[6] != 1 || req_y[6] != 1) begin
                n_bad++;
                $display("FAIL timeout_same_xy: got (%0d,%0d) then (%0d,%0d) want (1,1) twice", req_x[5], req_y[5], req_x[6], req_y[6]);
            end
        end
        repeat (30) tick();
        n_cmp++;
        if (err !== 1'b1 || wr_addr.size() != 5) begin
            n_bad++;
            $display("FAIL timeout_sticky: err=%0b writes=%0d want 1 5", err, wr_addr.size());
        end
        run = 1'b0;
        stuck_core = 0;
        reset_dut();
        n_cmp++;
        if (err !== 1'b0) begin
            n_bad++;
            $display("FAIL timeout_reset_clears: err=%0b want 0", err);
        end
    endtask

    task automatic test_reset_mid();
        bit ok;
        int n = 0;
        reset_dut();
        run = 1'b1;
        while (en_cyc.size() < 3 && n < 500) begin
            tick();
            n++;
        end
        tick();
        tick();
        n_cmp++;
        if (busy !== 1'b1 || fb_we !== 1'b0 || core_enable !== 1'b0) begin
            n_bad++;
            $display("FAIL midreset_pre: busy=%0b we=%0b en=%0b want 1 0 0", busy, fb_we, core_enable);
        end
        reset = 1'b1;
        tick();
        n_cmp++;
        if ({core_enable, core_x, core_y, fb_we, fb_addr, fb_data, busy, frame_done, frame_count, err} !== '0) begin
            n_bad++;
            $display("FAIL midreset_outputs: en=%0b x=%0d y=%0d we=%0b addr=%0d data=%0d busy=%0b cnt=%0d want all 0",
                     core_enable, core_x, core_y, fb_we, fb_addr, fb_data, busy, frame_count);
        end
        reset = 1'b0;
        clear_log();
        wait_frames(1, 1000, ok);
        run = 1'b0;
        tick();
        n_cmp++;
        if (!ok || en_busy != 0) begin
            n_bad++;
            $display("FAIL midreset_wait_ready: done=%0b enables_while_core_busy=%0d want 1 0", ok, en_busy);
        end
        n_cmp++;
        if (wr_addr.size() != NPX || wr_addr[0] != 0 || wr_data[0] != exp_data(0)) begin
            n_bad++;
            $display("FAIL midreset_first_write: writes=%0d first addr=%0d data=%0d want %0d writes from addr 0 data 0",
                     wr_addr.size(), wr_addr.size() > 0 ? wr_addr[0] : -1, wr_data.size() > 0 ? wr_data[0] : -1, NPX);
        end
        for (int i = 1; i < wr_addr.size() && i < NPX; i++) begin
            n_cmp++;
            if (wr_addr[i] != i || wr_data[i] != exp_data(i)) begin
                n_bad++;
                $display("FAIL midreset_px%0d: addr=%0d data=%0d want %0d %0d", i, wr_addr[i], wr_data[i], i, exp_data(i));
            end
        end
    endtask

    task automatic test_back_to_back();
        bit ok;
        reset_dut();
        rand_wait = 1;
        run = 1'b1;
        wait_frames(3, 4000, ok);
        run = 1'b0;
        tick();
        rand_wait = 0;
        n_cmp++;
        if (!ok || frame_count !== 16'd3) begin
            n_bad++;
            $display("FAIL b2b_frames: done=%0b count=%0d want 1 3", ok, frame_count);
        end
        n_cmp++;
        if (wr_addr.size() != 3 * NPX || req_x.size() != 3 * NPX || done_pos.size() != 3) begin
            n_bad++;
            $display("FAIL b2b_counts: writes=%0d reqs=%0d dones=%0d want %0d %0d 3", wr_addr.size(), req_x.size(), done_pos.size(), 3 * NPX, 3 * NPX);
        end
        for (int f = 0; f < done_pos.size() && f < 3; f++) begin
            n_cmp++;
            if (done_pos[f] != (f + 1) * NPX) begin
                n_bad++;
                $display("FAIL b2b_done%0d: after %0d writes want %0d", f, done_pos[f], (f + 1) * NPX);
            end
        end
        for (int i = 0; i < wr_addr.size() && i < req_x.size() && i < 3 * NPX; i++) begin
            n_cmp++;
            if (wr_addr[i] != i % NPX || wr_data[i] != exp_data(i % NPX) || req_x[i] != i % H || req_y[i] != (i / H) % V) begin
                n_bad++;
                $display("FAIL b2b_px%0d: addr=%0d data=%0d req=(%0d,%0d) want addr=%0d data=%0d req=(%0d,%0d)",
                         i, wr_addr[i], wr_data[i], req_x[i], req_y[i], i % NPX, exp_data(i % NPX), i % H, (i / H) % V);
            end
        end
        n_cmp++;
        if (hold_bad != 0 || overlap_err != 0) begin
            n_bad++;
            $display("FAIL b2b_protocol: hold_changes=%0d extra_enables=%0d want 0 0", hold_bad, overlap_err);
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_single_frame();
        test_fb_wait();
        test_run_drop();
        test_ack_timeout();
        test_reset_mid();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
